// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit that shifts one bit per clock and signals completion with a
// start/done handshake, so the control path can stall on shifts instead of using a barrel shifter.
module iterative_shift_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHAMT_BITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] shamt_ext,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpSll  = 2'b00;
  localparam logic [1:0] OpSrl  = 2'b01;
  localparam logic [1:0] OpSra  = 2'b10;
  localparam logic [1:0] OpPass = 2'b11;

  state_e                state_q;
  logic [WIDTH-1:0]      work_q;
  logic [SHAMT_BITS-1:0] count_q;
  logic [1:0]            op_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  accept;
  logic [SHAMT_BITS-1:0] shamt_lo;
  logic [WIDTH-1:0]      shifted;
  logic                  unused_shamt_hi;

  assign accept          = start && (state_q != StShift);
  assign shamt_lo        = shamt_ext[SHAMT_BITS-1:0];
  // Upper extender bits carry no information for the shift count.
  assign unused_shamt_hi = ^shamt_ext[WIDTH-1:SHAMT_BITS];

  always_comb begin
    shifted = work_q;
    unique case (op_q)
      OpSll:   shifted = {work_q[WIDTH-2:0], 1'b0};
      OpSrl:   shifted = {1'b0, work_q[WIDTH-1:1]};
      OpSra:   shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shifted = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      count_q <= '0;
      op_q    <= OpSll;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      if (accept) begin
        work_q  <= operand;
        op_q    <= op;
        count_q <= shamt_lo;
        if ((shamt_lo != '0) && (op != OpPass)) begin
          state_q <= StShift;
          busy_q  <= 1'b1;
        end else begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StShift: begin
            work_q  <= shifted;
            count_q <= count_q - 1'b1;
            if (count_q == SHAMT_BITS'(1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = work_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit: latency, busy/done counts, results, reset abort and
// back-to-back acceptance.
module tb_iterative_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [31:0] shamt_ext;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_shift_unit #(
    .WIDTH      (32),
    .SHAMT_BITS (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand   (operand),
    .shamt_ext (shamt_ext),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one op in cycle 0 (inputs set on a negedge), observe 40 following cycles.
  // inj_cycle > 0 raises a second start with different inputs in that cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] opnd,
                        input logic [31:0] sh, input int inj_cycle, input int exp_done_cyc,
                        input int exp_busy, input logic [31:0] exp_res);
    int          done_cyc;
    int          busy_cnt;
    int          done_cnt;
    logic [31:0] res;
    done_cyc = -1;
    busy_cnt = 0;
    done_cnt = 0;
    res      = 32'hx;
    @(negedge clk);
    start     = 1'b1;
    op        = o;
    operand   = opnd;
    shamt_ext = sh;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          res      = result;
        end
      end
      start     = 1'b0;
      op        = 2'b01;
      operand   = 32'hA5A5A5A5;
      shamt_ext = 32'd5;
      if (k == inj_cycle) begin
        start     = 1'b1;
        op        = 2'b00;
        operand   = 32'h0000FFFF;
        shamt_ext = 32'd1;
      end
    end
    check_eq({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    check_eq({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check_eq({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({tag, " result"}, res, exp_res);
    check_eq({tag, " result_held"}, result, exp_res);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    op        = 2'b00;
    operand   = '0;
    shamt_ext = '0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset result", result, 32'd0);
    reset = 1'b0;

    run_op("sll4", 2'b00, 32'h00000001, 32'h00000004, 0, 5, 4, 32'h00000010);
    run_op("sra31", 2'b10, 32'h80000000, 32'h0000001F, 0, 32, 31, 32'hFFFFFFFF);
    run_op("srl31", 2'b01, 32'h80000000, 32'h0000001F, 0, 32, 31, 32'h00000001);
    run_op("zero", 2'b00, 32'hDEADBEEF, 32'h00000000, 0, 1, 0, 32'hDEADBEEF);
    run_op("pass", 2'b11, 32'hDEADBEEF, 32'h00000007, 0, 1, 0, 32'hDEADBEEF);
    run_op("upper", 2'b01, 32'h000000F0, 32'hFFFFFFE3, 0, 4, 3, 32'h0000001E);
    run_op("ignore", 2'b00, 32'h00000001, 32'h00000008, 3, 9, 8, 32'h00000100);

    // Reset mid-shift aborts the op with no done pulse.
    begin
      int late_done;
      late_done = 0;
      @(negedge clk);
      start = 1'b1; op = 2'b01; operand = 32'hFFFFFFFF; shamt_ext = 32'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("abort busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("abort busy", 32'(busy), 32'd0);
      check_eq("abort done", 32'(done), 32'd0);
      check_eq("abort result", result, 32'd0);
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (done) late_done++;
      end
      check_eq("abort no_done", 32'(late_done), 32'd0);
    end

    // Start coincident with reset is dropped.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 2'b00; operand = 32'h12345678; shamt_ext = 32'd0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("rst_start done", 32'(done), 32'd0);
    check_eq("rst_start result", result, 32'd0);

    // Back-to-back: second start during DONE, no idle gap.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand = 32'h00000001; shamt_ext = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("b2b first_done", 32'(done), 32'd1);
    check_eq("b2b first_result", result, 32'h00000004);
    start = 1'b1; op = 2'b01; operand = 32'h00000100; shamt_ext = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b c4 busy", 32'(busy), 32'd1);
    check_eq("b2b c4 done", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("b2b c5 busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("b2b c6 busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("b2b c7 done", 32'(done), 32'd1);
    check_eq("b2b c7 busy", 32'(busy), 32'd0);
    check_eq("b2b result", result, 32'h00000020);
    @(negedge clk);
    check_eq("b2b idle done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
